// File: rtl/rtc_pkg.sv
// rtc_pkg: BCD time type, per-field limits and time helpers shared by the RTC alarm bank.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package rtc_pkg;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  localparam logic [7:0] SS_MAX = 8'h59;
  localparam logic [7:0] MM_MAX = 8'h59;
  localparam logic [7:0] HH_MAX = 8'h23;

  // Once both digits are legal BCD, a plain unsigned compare orders BCD bytes numerically.
  function automatic logic bcd_byte_valid(input logic [7:0] b, input logic [7:0] max);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
  endfunction

  function automatic logic bcd_time_valid(input bcd_time_t t);
    return bcd_byte_valid(t.hh, HH_MAX) && bcd_byte_valid(t.mm, MM_MAX) &&
           bcd_byte_valid(t.ss, SS_MAX);
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {4'(tens), 4'(ones)};
  endfunction

  // Adds 1..59 minutes; minute overflow carries into the hour, which wraps 23 -> 00.
  function automatic bcd_time_t bcd_add_min(input bcd_time_t t, input int unsigned mins);
    logic [6:0] m;
    logic [6:0] h;
    bcd_time_t  r;
    m = bcd_to_bin(t.mm) + 7'(mins);
    h = bcd_to_bin(t.hh);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 7'd1;
    end
    if (h >= 7'd24) h = h - 7'd24;
    r.hh = bin_to_bcd(h);
    r.mm = bin_to_bcd(m);
    r.ss = t.ss;
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter 00..MAX with synchronous load and carry out.
// Latency: q updates one cycle after load/inc; q_nxt and carry_out are combinational.
// Backpressure: none; load takes priority over inc.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] q,
  output logic [7:0] q_nxt,
  output logic       carry_out
);

  // Next value: load, else BCD increment with digit and MAX rollover.
  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = load_val;
    end else if (inc) begin
      if (q == MAX)              q_nxt = 8'h00;
      else if (q[3:0] == 4'd9)   q_nxt = {q[7:4] + 4'd1, 4'd0};
      else                       q_nxt = {q[7:4], q[3:0] + 4'd1};
    end
  end

  assign carry_out = inc && !load && (q == MAX);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 8'h00;
    else        q <= q_nxt;
  end

endmodule

// File: rtl/bcd_rtc_alarm_bank.sv
// bcd_rtc_alarm_bank: BCD hh:mm:ss clock with prescaler, N alarm slots, hourly chime, 12h view.
// Latency: time/tick/hit/load_err registered one cycle after the wrap or strobe; disp_bcd/pm combinational.
// Backpressure: none; strobes are accepted every cycle. Optional snooze shadows: RTC_SNOOZE_EN.
module bcd_rtc_alarm_bank
  import rtc_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int N_ALARM     = 4,
  parameter int SNOOZE_MIN  = 5,
  localparam int AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                set_time,
  input  logic [23:0]         wr_time,
  input  logic                alarm_wr,
  input  logic [AW-1:0]       alarm_idx,
  input  logic [23:0]         alarm_time,
  input  logic                alarm_en_in,
  input  logic [N_ALARM-1:0]  alarm_ack,
  input  logic [N_ALARM-1:0]  snooze,
  input  logic                mode_12h,
  output logic [23:0]         time_bcd,
  output logic [23:0]         disp_bcd,
  output logic                pm,
  output logic                tick,
  output logic                on_the_hour,
  output logic [N_ALARM-1:0]  alarm_hit,
  output logic                load_err
);

  localparam int            CW       = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(CLK_PER_SEC - 1);

  logic [CW-1:0] pre_cnt;
  bcd_time_t     wr_t, al_wr_t, cur_time, nxt_time;
  logic          time_ok, load_time, wrap, adv, al_ok, idx_ok;
  logic [7:0]    ss_q, mm_q, hh_q, ss_n, mm_n, hh_n;
  logic          ss_carry, mm_carry, hh_carry_unused;

  assign wr_t      = wr_time;
  assign al_wr_t   = alarm_time;
  assign time_ok   = bcd_time_valid(wr_t);
  assign al_ok     = bcd_time_valid(al_wr_t);
  assign load_time = set_time && time_ok;
  assign wrap      = run && (pre_cnt == PRE_LAST);
  // A valid load in the wrap cycle swallows that second's advance.
  assign adv       = wrap && !load_time;

  // Prescaler: counts while running, cleared by a wrap or a time load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pre_cnt <= '0;
    else if (load_time || wrap) pre_cnt <= '0;
    else if (run)              pre_cnt <= pre_cnt + CW'(1);
  end

  bcd_mod_counter #(.MAX(SS_MAX)) u_ss (
    .clk, .rst_n, .load(load_time), .load_val(wr_t.ss), .inc(adv),
    .q(ss_q), .q_nxt(ss_n), .carry_out(ss_carry)
  );
  bcd_mod_counter #(.MAX(MM_MAX)) u_mm (
    .clk, .rst_n, .load(load_time), .load_val(wr_t.mm), .inc(ss_carry),
    .q(mm_q), .q_nxt(mm_n), .carry_out(mm_carry)
  );
  bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
    .clk, .rst_n, .load(load_time), .load_val(wr_t.hh), .inc(mm_carry),
    .q(hh_q), .q_nxt(hh_n), .carry_out(hh_carry_unused)
  );

  assign cur_time = {hh_q, mm_q, ss_q};
  assign nxt_time = {hh_n, mm_n, ss_n};
  assign time_bcd = cur_time;

  // Strobe outputs: tick/chime follow real advances only, load_err flags any rejected write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick        <= 1'b0;
      on_the_hour <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      tick        <= adv;
      on_the_hour <= adv && (nxt_time.mm == 8'h00) && (nxt_time.ss == 8'h00);
      load_err    <= (set_time && !time_ok) || (alarm_wr && !(al_ok && idx_ok));
    end
  end

  bcd_time_t          al_time [N_ALARM];
  logic [N_ALARM-1:0] al_en, wr_sel, prog_match, hit_set, hit_clr;

  // Slot decode and programmed-time match against the time about to be registered.
  always_comb begin
    idx_ok     = 1'b0;
    wr_sel     = '0;
    prog_match = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (alarm_idx == AW'(i)) idx_ok = 1'b1;
      wr_sel[i]     = alarm_wr && al_ok && (alarm_idx == AW'(i));
      prog_match[i] = adv && al_en[i] && (al_time[i] == nxt_time);
    end
  end

  // Slot storage: time and enable written together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ALARM; i++) begin
        al_time[i] <= '0;
        al_en[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (wr_sel[i]) begin
          al_time[i] <= al_wr_t;
          al_en[i]   <= alarm_en_in;
        end
      end
    end
  end

`ifdef RTC_SNOOZE_EN
  bcd_time_t          sh_time [N_ALARM];
  logic [N_ALARM-1:0] sh_arm, sh_match, snz_go;

  // Shadow match and snooze acceptance (only a pending hit can be snoozed).
  always_comb begin
    sh_match = '0;
    snz_go   = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      sh_match[i] = adv && sh_arm[i] && (sh_time[i] == nxt_time);
      snz_go[i]   = snooze[i] && alarm_hit[i];
    end
  end

  // Shadow alarms: armed by snooze, disarmed by firing or by reprogramming the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ALARM; i++) begin
        sh_time[i] <= '0;
        sh_arm[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (wr_sel[i]) begin
          sh_arm[i] <= 1'b0;
        end else if (snz_go[i]) begin
          sh_time[i] <= bcd_add_min(cur_time, SNOOZE_MIN);
          sh_arm[i]  <= 1'b1;
        end else if (sh_match[i]) begin
          sh_arm[i] <= 1'b0;
        end
      end
    end
  end

  assign hit_set = prog_match | sh_match;
  assign hit_clr = alarm_ack | wr_sel | snz_go;
`else
  logic unused_snooze;
  localparam int unused_snooze_min = SNOOZE_MIN;
  assign unused_snooze = ^snooze;
  assign hit_set = prog_match;
  assign hit_clr = alarm_ack | wr_sel;
`endif

  // Sticky hit flags: a new match beats any same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_hit <= '0;
    else        alarm_hit <= (alarm_hit & ~hit_clr) | hit_set;
  end

  logic [6:0] hh_bin;
  logic [7:0] disp_hh;

  // Display view: 00 shows as 12 AM, 13..23 fold to 01..11 PM.
  always_comb begin
    hh_bin  = bcd_to_bin(cur_time.hh);
    pm      = (hh_bin >= 7'd12);
    disp_hh = cur_time.hh;
    if (mode_12h) begin
      if (hh_bin == 7'd0)       disp_hh = 8'h12;
      else if (hh_bin > 7'd12)  disp_hh = bin_to_bcd(hh_bin - 7'd12);
    end
    disp_bcd = {disp_hh, cur_time.mm, cur_time.ss};
  end

endmodule

// File: tb/tb_bcd_rtc_alarm_bank.sv
`timescale 1ns/1ps
module tb_bcd_rtc_alarm_bank;

  localparam int CPS = 4;
  localparam int NA  = 4;

  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, set_time = 1'b0;
  logic        alarm_wr = 1'b0, alarm_en_in = 1'b0, mode_12h = 1'b0;
  logic [23:0] wr_time = '0, alarm_time = '0;
  logic [1:0]  alarm_idx = '0;
  logic [3:0]  alarm_ack = '0, snooze = '0;
  logic [23:0] time_bcd, disp_bcd;
  logic        pm, tick, on_the_hour, load_err;
  logic [3:0]  alarm_hit;

  bcd_rtc_alarm_bank #(.CLK_PER_SEC(CPS), .N_ALARM(NA), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .set_time(set_time), .wr_time(wr_time),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_time(alarm_time),
    .alarm_en_in(alarm_en_in), .alarm_ack(alarm_ack), .snooze(snooze),
    .mode_12h(mode_12h), .time_bcd(time_bcd), .disp_bcd(disp_bcd), .pm(pm),
    .tick(tick), .on_the_hour(on_the_hour), .alarm_hit(alarm_hit), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int mt     = 0;   // model time in seconds since midnight

  typedef struct { logic [23:0] t; logic oth; } tick_exp_t;
  tick_exp_t sb[$];
  tick_exp_t mon_e;

  typedef struct {
    logic [23:0] t;
    logic        m12;
    logic        err;
    logic [23:0] exp_t;
    logic [23:0] exp_d;
    logic        exp_pm;
  } vec_t;
  vec_t vec [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  function automatic logic [23:0] s2b(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int b2s(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
           (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
            int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Tick scoreboard: every tick pops one predicted time/chime pair.
  always @(negedge clk) begin
    if (tick) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_tick: got tick at time %h, required no tick", time_bcd);
      end else begin
        mon_e = sb.pop_front();
        chk("tick_time", 32'(time_bcd), 32'(mon_e.t));
        chk("tick_chime", 32'(on_the_hour), 32'(mon_e.oth));
      end
    end else if (on_the_hour) begin
      n_chk++;
      $display("FAIL chime_without_tick: got on_the_hour 1, required 0");
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [23:0] t);
    wr_time  = t;
    set_time = 1'b1;
    step();
    set_time = 1'b0;
  endtask

  task automatic do_alarm(input logic [1:0] idx, input logic [23:0] t, input logic en);
    alarm_idx   = idx;
    alarm_time  = t;
    alarm_en_in = en;
    alarm_wr    = 1'b1;
    step();
    alarm_wr    = 1'b0;
  endtask

  task automatic expect_tick();
    tick_exp_t e;
    mt    = (mt + 1) % 86400;
    e.t   = s2b(mt);
    e.oth = (mt % 3600) == 0;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    chk("ticks_all_seen", 32'(sb.size()), 32'd0);
    sb.delete();
    step();
  endtask

  task automatic run_secs(input int n);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_tick();
      step(CPS);
    end
    run = 1'b0;
    settle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    //             wr_time     m12   err   exp_t       exp_d       pm
    vec[0]  = '{24'h001500, 1'b1, 1'b0, 24'h001500, 24'h121500, 1'b0};
    vec[1]  = '{24'h120000, 1'b1, 1'b0, 24'h120000, 24'h120000, 1'b1};
    vec[2]  = '{24'h130500, 1'b1, 1'b0, 24'h130500, 24'h010500, 1'b1};
    vec[3]  = '{24'h235959, 1'b1, 1'b0, 24'h235959, 24'h115959, 1'b1};
    vec[4]  = '{24'h115959, 1'b1, 1'b0, 24'h115959, 24'h115959, 1'b0};
    vec[5]  = '{24'h203000, 1'b1, 1'b0, 24'h203000, 24'h083000, 1'b1};
    vec[6]  = '{24'h127A00, 1'b1, 1'b1, 24'h203000, 24'h083000, 1'b1};
    vec[7]  = '{24'h240000, 1'b0, 1'b1, 24'h203000, 24'h203000, 1'b1};
    vec[8]  = '{24'h096000, 1'b0, 1'b1, 24'h203000, 24'h203000, 1'b1};
    vec[9]  = '{24'h1A0000, 1'b0, 1'b1, 24'h203000, 24'h203000, 1'b1};
    vec[10] = '{24'h070809, 1'b0, 1'b0, 24'h070809, 24'h070809, 1'b0};

    // Reset state
    step(2);
    chk("rst_time", 32'(time_bcd), 32'h0);
    chk("rst_disp", 32'(disp_bcd), 32'h0);
    chk("rst_flags", {28'h0, tick, on_the_hour, load_err, pm}, 32'h0);
    chk("rst_hit", 32'(alarm_hit), 32'h0);
    rst_n = 1'b1;
    step();

    // Free run: 8 cycles -> two seconds
    mt = 0;
    run_secs(2);
    chk("run_8cyc_time", 32'(time_bcd), 32'h000002);

    // Day rollover with hourly chime lasting one cycle
    do_set(24'h235959);
    chk("set_235959", 32'(time_bcd), 32'h235959);
    mt = b2s(24'h235959);
    run_secs(1);
    chk("chime_one_cycle", 32'(on_the_hour), 32'h0);
    chk("tick_one_cycle", 32'(tick), 32'h0);

    // Rejected loads
    do_set(24'h127A00);
    chk("bad_set_err", 32'(load_err), 32'h1);
    chk("bad_set_time", 32'(time_bcd), 32'h000000);
    step();
    chk("err_one_cycle", 32'(load_err), 32'h0);
    do_alarm(2'd1, 24'h240000, 1'b1);
    chk("bad_alarm_err", 32'(load_err), 32'h1);

    // Load validity and display table
    for (int i = 0; i < 11; i++) begin
      mode_12h = vec[i].m12;
      do_set(vec[i].t);
      chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vec[i].err));
      chk($sformatf("vec%0d_time", i), 32'(time_bcd), 32'(vec[i].exp_t));
      chk($sformatf("vec%0d_disp", i), 32'(disp_bcd), 32'(vec[i].exp_d));
      chk($sformatf("vec%0d_pm", i), 32'(pm), 32'(vec[i].exp_pm));
    end
    mode_12h = 1'b0;

    // Alarm match: enabled slot 2 fires, disabled slot 3 does not
    do_alarm(2'd2, 24'h063005, 1'b1);
    do_alarm(2'd3, 24'h063005, 1'b0);
    do_set(24'h063004);
    chk("load_no_fire", 32'(alarm_hit), 32'h0);
    mt = b2s(24'h063004);
    run_secs(1);
    chk("alarm_fire", 32'(alarm_hit), 32'b0100);

    // Ack in the same cycle as a re-match: set wins
    do_set(24'h063004);
    mt = b2s(24'h063004);
    run = 1'b1;
    expect_tick();
    step(CPS - 1);
    alarm_ack = 4'b0100;
    step();
    alarm_ack = 4'b0000;
    run = 1'b0;
    chk("ack_vs_match", 32'(alarm_hit), 32'b0100);
    settle();
    alarm_ack = 4'b0100;
    step();
    alarm_ack = 4'b0000;
    chk("ack_clears", 32'(alarm_hit), 32'b0000);

    // Rewriting a slot clears its hit
    do_set(24'h063004);
    mt = b2s(24'h063004);
    run_secs(1);
    chk("refire", 32'(alarm_hit), 32'b0100);
    do_alarm(2'd2, 24'h070000, 1'b1);
    chk("wr_clears_hit", 32'(alarm_hit), 32'b0000);

    // set_time in the wrap cycle: no tick, load wins
    do_set(24'h100000);
    run = 1'b1;
    step(CPS - 1);
    wr_time  = 24'h111111;
    set_time = 1'b1;
    step();
    set_time = 1'b0;
    run = 1'b0;
    settle();
    chk("set_beats_wrap", 32'(time_bcd), 32'h111111);

    // Pause mid-count holds prescaler and time
    do_set(24'h010000);
    mt = b2s(24'h010000);
    expect_tick();
    run = 1'b1;
    step(2);
    run = 1'b0;
    step(10);
    chk("pause_hold", 32'(time_bcd), 32'h010000);
    run = 1'b1;
    step(2);
    run = 1'b0;
    settle();
    chk("resume_tick", 32'(time_bcd), 32'h010001);

    // Snooze on slot 0 near midnight
    do_alarm(2'd0, 24'h235800, 1'b1);
    do_set(24'h235759);
    mt = b2s(24'h235759);
    run_secs(1);
    chk("slot0_fire", 32'(alarm_hit), 32'b0001);
    snooze = 4'b0001;
    step();
    snooze = 4'b0000;
`ifdef RTC_SNOOZE_EN
    chk("snooze_clears", 32'(alarm_hit), 32'b0000);
    run_secs(299);
    chk("snooze_not_early", 32'(alarm_hit), 32'b0000);
    run_secs(1);
    chk("snooze_time", 32'(time_bcd), 32'h000300);
    chk("snooze_refire", 32'(alarm_hit), 32'b0001);
`else
    chk("snooze_ignored", 32'(alarm_hit), 32'b0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
